// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/step/drain controller for a pipelined core; STEP mode enabled by PIPE_RUN_CTRL_STEP_EN.
module pipe_run_ctrl #(
  parameter int N_STAGES = 5,
  parameter int NB_INSTR = 32,
  parameter int NB_OPCODE = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic                 i_stop,
  input  logic                 i_clear,
  input  logic [NB_INSTR-1:0]  i_instr,
  output logic                 o_valid,
  output logic                 o_fetch_stall,
  output logic                 o_done,
  output logic [NB_CYCLES-1:0] o_cycles,
  output logic [2:0]           o_state
);
  localparam int NB_DRAIN = $clog2(N_STAGES);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
  state_t state, nxt;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic halt, step_req, clear_ok;
  logic unused_bits;
`ifdef PIPE_RUN_CTRL_STEP_EN
  assign step_req = i_step;
  assign unused_bits = ^i_instr;
`else
  assign step_req = 1'b0;
  assign unused_bits = ^{i_instr, i_step};
`endif
  assign o_valid = state == RUN || state == STEP || state == DRAIN;
  assign o_fetch_stall = state == DRAIN;
  assign o_done = state == DONE;
  assign o_state = state;
  assign halt = o_valid && i_instr[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE;
  assign clear_ok = i_clear && (state == IDLE || state == DONE);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_start ? RUN : step_req ? STEP : IDLE;
      RUN:     nxt = i_stop ? IDLE : halt ? DRAIN : RUN;
      STEP:    nxt = halt ? DRAIN : IDLE;
      DRAIN:   nxt = drain_cnt == NB_DRAIN'(1) ? DONE : DRAIN;
      DONE:    nxt = i_clear ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      drain_cnt <= '0;
      o_cycles <= '0;
    end else begin
      state <= nxt;
      drain_cnt <= (nxt == DRAIN && state != DRAIN) ? NB_DRAIN'(N_STAGES - 1) :
                   state == DRAIN ? drain_cnt - NB_DRAIN'(1) : drain_cnt;
      o_cycles <= clear_ok ? '0 :
                  (o_valid && o_cycles != '1) ? o_cycles + NB_CYCLES'(1) : o_cycles;
    end
  end
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: table-driven and sequence checks of pipe_run_ctrl, plus a 4-bit counter instance for saturation.
module tb_pipe_run_ctrl;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  localparam logic [31:0] NOHALT_I = 32'hF83F_FFFF;
  logic clk = 1'b0;
  logic i_reset = 1'b1, i_start = 1'b0, i_step = 1'b0, i_stop = 1'b0, i_clear = 1'b0;
  logic [31:0] i_instr = NOHALT_I;
  logic o_valid, o_fetch_stall, o_done, v4, f4, d4;
  logic [31:0] o_cycles;
  logic [3:0] c4;
  logic [2:0] o_state, s4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_run_ctrl dut (.i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_step(i_step),
    .i_stop(i_stop), .i_clear(i_clear), .i_instr(i_instr), .o_valid(o_valid),
    .o_fetch_stall(o_fetch_stall), .o_done(o_done), .o_cycles(o_cycles), .o_state(o_state));
  pipe_run_ctrl #(.NB_CYCLES(4)) dut4 (.i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_step(i_step),
    .i_stop(i_stop), .i_clear(i_clear), .i_instr(i_instr), .o_valid(v4),
    .o_fetch_stall(f4), .o_done(d4), .o_cycles(c4), .o_state(s4));
  typedef struct {
    logic s, st, sp, cl, h;
    logic v, f, d;
    int state, cyc;
  } vec_t;
  vec_t vec [20];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic tick(input logic s, input logic st, input logic sp, input logic cl, input logic h);
    @(negedge clk);
    i_start = s; i_step = st; i_stop = sp; i_clear = cl;
    i_instr = h ? HALT_I : NOHALT_I;
    @(posedge clk);
    #1;
    i_start = 0; i_step = 0; i_stop = 0; i_clear = 0; i_instr = NOHALT_I;
  endtask
  task automatic do_reset;
    @(negedge clk);
    i_reset = 1;
    @(negedge clk);
    i_reset = 0;
  endtask
  task automatic chk_all(input string name, input int v, input int f, input int d, input int st, input int cyc);
    chk({name, ".valid"}, int'(o_valid), v);
    chk({name, ".stall"}, int'(o_fetch_stall), f);
    chk({name, ".done"}, int'(o_done), d);
    chk({name, ".state"}, int'(o_state), st);
    chk({name, ".cycles"}, int'(o_cycles), cyc);
  endtask
  initial begin
    int vc, sc, sbad, gap;
    vec = '{
      '{0,0,0,0,0, 0,0,0,0,0}, '{1,0,0,0,0, 1,0,0,1,0}, '{0,0,0,0,0, 1,0,0,1,1},
      '{0,0,0,0,0, 1,0,0,1,2}, '{0,0,1,0,0, 0,0,0,0,3}, '{0,0,0,1,0, 0,0,0,0,0},
      '{1,1,0,0,0, 1,0,0,1,0}, '{0,0,0,0,1, 1,1,0,3,1}, '{1,1,1,1,0, 1,1,0,3,2},
      '{0,0,0,0,0, 1,1,0,3,3}, '{0,0,0,0,0, 1,1,0,3,4}, '{0,0,0,0,0, 0,0,1,4,5},
      '{1,1,0,0,0, 0,0,1,4,5}, '{0,0,0,1,0, 0,0,0,0,0}, '{0,0,0,0,1, 0,0,0,0,0},
      '{1,0,0,0,1, 1,0,0,1,0}, '{0,0,1,0,1, 0,0,0,0,1}, '{1,0,0,0,0, 1,0,0,1,1},
      '{0,0,0,1,0, 1,0,0,1,2}, '{0,0,0,0,1, 1,1,0,3,3}};
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    i_reset = 0;
    for (int i = 0; i < 20; i++) begin
      tick(vec[i].s, vec[i].st, vec[i].sp, vec[i].cl, vec[i].h);
      chk_all($sformatf("vec%0d", i), vec[i].v, vec[i].f, vec[i].d, vec[i].state, vec[i].cyc);
    end
    do_reset();
    tick(1, 0, 0, 0, 0);
    vc = 0; sc = 0; sbad = 0; gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid) begin
        vc++;
        if (gap != 0) sbad++;
      end else gap = 1;
      if (o_fetch_stall) begin
        sc++;
        if (vc <= 10) sbad++;
      end
      i_instr = (i == 9) ? HALT_I : NOHALT_I;
      @(posedge clk);
    end
    @(negedge clk);
    i_instr = NOHALT_I;
    chk("halt_run.valid_cycles", vc, 14);
    chk("halt_run.stall_cycles", sc, 4);
    chk("halt_run.order", sbad, 0);
    chk_all("halt_run.end", 0, 0, 1, 4, 14);
    do_reset();
    tick(1, 0, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("pause1.cycles", int'(o_cycles), 6);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk_all("pause2", 0, 0, 0, 0, 8);
    do_reset();
    tick(1, 0, 0, 0, 0);
    repeat (15) tick(0, 0, 0, 0, 0);
    chk("sat.c4_at15", int'(c4), 15);
    repeat (5) tick(0, 0, 0, 0, 0);
    chk("sat.c4_hold", int'(c4), 15);
    chk("sat.c32", int'(o_cycles), 20);
    do_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    chk("drain2.state", int'(o_state), 3);
    #1 i_reset = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    i_reset = 0;
    tick(1, 0, 0, 0, 0);
    chk_all("restart", 1, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    chk("restart.count", int'(o_cycles), 1);
    do_reset();
`ifdef PIPE_RUN_CTRL_STEP_EN
    for (int p = 0; p < 3; p++) begin
      tick(0, 1, 0, 0, 0);
      chk($sformatf("step%0d.state", p), int'(o_state), 2);
      chk($sformatf("step%0d.valid", p), int'(o_valid), 1);
      tick(0, 0, 0, 0, 0);
      chk($sformatf("step%0d.back", p), int'(o_state), 0);
      chk($sformatf("step%0d.novalid", p), int'(o_valid), 0);
      repeat (2) tick(0, 0, 0, 0, 0);
    end
    chk("step.cycles", int'(o_cycles), 3);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("step_halt.state", int'(o_state), 3);
`else
    tick(0, 1, 0, 0, 0);
    chk("nostep.valid", int'(o_valid), 0);
    chk("nostep.state", int'(o_state), 0);
    tick(0, 0, 0, 0, 0);
    chk("nostep.cycles", int'(o_cycles), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 5; pipeline depth in stages, minimum 2.
REQ-002 SHALL have parameter NB_INSTR, default 32; fetched instruction width.
REQ-003 SHALL have parameter NB_OPCODE, default 6; opcode field width, occupying instruction bits [NB_INSTR-1 -: NB_OPCODE].
REQ-004 SHALL have parameter HALT_OPCODE, default 6'b111111; opcode that terminates a program.
REQ-005 SHALL have parameter NB_CYCLES, default 32; cycle counter width.
REQ-006 SHALL have port i_clock  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port i_start  input  1  one-cycle pulse; begin or resume continuous run.
REQ-009 SHALL have port i_step  input  1  one-cycle pulse; advance the pipeline one cycle.
REQ-010 SHALL have port i_stop  input  1  one-cycle pulse; pause a continuous run.
REQ-011 SHALL have port i_clear  input  1  one-cycle pulse; zero the counter and leave DONE.
REQ-012 SHALL have port i_instr  input  NB_INSTR  instruction currently presented by fetch.
REQ-013 SHALL have port o_valid  output  1  pipeline advance enable, driving every stage valid.
REQ-014 SHALL have port o_fetch_stall  output  1  freezes the PC and injects NOP into decode.
REQ-015 SHALL have port o_done  output  1  program has halted and the pipeline is drained.
REQ-016 SHALL have port o_cycles  output  NB_CYCLES  count of cycles with o_valid=1.
REQ-017 SHALL have port o_state  output  3  current state: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.

Function
REQ-018 SHALL be a Moore FSM; o_valid=1 in RUN, STEP and DRAIN and 0 in IDLE and DONE; o_fetch_stall=1 only in DRAIN; o_done=1 only in DONE.
REQ-019 In IDLE, i_start SHALL enter RUN on the next edge; i_step SHALL enter STEP; i_start SHALL win when both are asserted.
REQ-020 In RUN, with i_stop=1, the FSM SHALL return to IDLE; otherwise, an opcode equal to HALT_OPCODE SHALL enter DRAIN; otherwise it SHALL remain in RUN.
REQ-021 STEP SHALL last exactly one cycle, then enter DRAIN if a halt opcode was sampled in that cycle, else IDLE.
REQ-022 On DRAIN entry, a drain counter SHALL load N_STAGES-1.
REQ-023 DRAIN SHALL decrement the drain counter each cycle and enter DONE after exactly N_STAGES-1 cycles.
REQ-024 i_stop, i_start and i_step SHALL be ignored in DRAIN.
REQ-025 DONE SHALL ignore i_start and i_step; i_clear SHALL zero o_cycles and enter IDLE.
REQ-026 In IDLE, i_clear SHALL zero o_cycles only.
REQ-027 i_clear SHALL be ignored in RUN, STEP and DRAIN.
REQ-028 o_cycles SHALL increment by 1 on every edge where o_valid=1, saturate at 2^NB_CYCLES-1 (no wrap), and hold otherwise.
REQ-029 Halt detection SHALL compare only the opcode field and SHALL be qualified by o_valid=1.
REQ-030 With i_stop and a halt opcode simultaneous in RUN, i_stop SHALL win; the halt instruction is re-presented on resume.

Reset
REQ-031 i_reset=1 SHALL force, without waiting for a clock edge: state IDLE, drain counter 0, o_cycles 0, o_valid 0, o_fetch_stall 0, o_done 0, o_state 0.
REQ-032 Reset asserted mid-RUN, STEP or DRAIN SHALL abort without completing the drain.
REQ-033 After reset release, the first transition SHALL occur on the first edge with a command asserted.

Configuration
REQ-034 With macro PIPE_RUN_CTRL_STEP_EN defined, STEP state and i_step behaviour SHALL be as specified above.
REQ-035 Without PIPE_RUN_CTRL_STEP_EN, i_step SHALL be ignored and STEP unreachable; the port and the o_state encoding SHALL remain unchanged.

Verification
REQ-036 N_STAGES=5: i_start, halt opcode on the 10th valid cycle -> o_valid high 14 consecutive cycles, o_fetch_stall high for the last 4, then o_done=1, o_cycles=14, o_state=4.
REQ-037 STEP_EN defined: three i_step pulses 4 cycles apart, no halt -> exactly 3 single-cycle o_valid pulses, o_cycles=3, o_state back to 0 after each.
REQ-038 i_start; i_stop after 6 valid cycles; i_start; i_stop after 2 more -> o_cycles=8, o_state=0, o_done=0.
REQ-039 NB_CYCLES=4: run 20 cycles without halt -> o_cycles saturates at 15.
REQ-040 i_reset asserted in the 2nd DRAIN cycle -> all outputs 0 immediately without a clock edge; after release and i_start -> o_state=1, counting restarts from 0.
REQ-041 Without STEP_EN: i_step pulse in IDLE -> o_valid stays 0, o_state stays 0.
